// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM state encoding and datapath mux encodings
// for the multicycle MIPS controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_JR     = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_JUMP    = 2'b10;
  localparam logic [1:0] PC_REGA    = 2'b11;

  localparam logic [1:0] RD_RT      = 2'b00;
  localparam logic [1:0] RD_RD      = 2'b01;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational state-to-control decode; Moore except pc_write in BRANCH (follows zero)
// and the mem_ready-qualified ir_write/pc_write in FETCH.
module mips_mc_decode
  import mips_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_mem_ready,
  input  logic       i_zero,
  output logic       o_pc_write,
  output logic       o_ir_write,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_alu_src_a,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src
);

  always_comb begin
    o_pc_write   = 1'b0;
    o_ir_write   = 1'b0;
    o_iord       = 1'b0;
    o_mem_read   = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_reg_dst    = RD_RT;
    o_mem_to_reg = M2R_ALUOUT;
    o_alu_src_b  = SRCB_B;
    o_alu_op     = ALU_ADD;
    o_pc_src     = PC_ALU;
    case (i_state)
      S_FETCH: begin
        o_mem_read  = 1'b1;
        o_alu_src_b = SRCB_4;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: o_alu_src_b = SRCB_IMMSH;
      S_MEMADR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        o_mem_read = 1'b1;
        o_iord     = 1'b1;
      end
      S_MEMWB: begin
        o_reg_write  = 1'b1;
        o_mem_to_reg = M2R_MDR;
      end
      S_MEMWR: begin
        o_mem_write = 1'b1;
        o_iord      = 1'b1;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
        o_reg_dst   = RD_RD;
      end
      S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: o_reg_write = 1'b1;
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_SUB;
        o_pc_src    = PC_ALUOUT;
        o_pc_write  = i_zero;
      end
      S_JUMP: begin
        o_pc_src   = PC_JUMP;
        o_pc_write = 1'b1;
      end
      S_JR: begin
        o_pc_src   = PC_REGA;
        o_pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM with retired-instruction counter and sticky illegal flag.
// 3-5 cycles per instruction plus one per memory wait cycle; mem_ready stalls FETCH/MEMRD/MEMWR.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_src,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count,
  output logic               illegal
);

  state_t               r_state;
  state_t               w_next;
  logic                 w_retire;
  logic                 w_bad_op;
  logic [COUNT_W-1:0]   r_count;
  logic                 r_illegal;
  state_t               w_dec_state;
  logic                 w_dec_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    w_bad_op = 1'b0;
    case (r_state)
      S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = (funct == FN_JR) ? S_JR : S_EXEC;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_BEQ:       w_next = S_BRANCH;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next   = S_FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        w_next   = mem_ready ? S_FETCH : S_MEMWR;
        w_retire = mem_ready;
      end
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP, S_JR: w_retire = 1'b1;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_retire) r_count <= r_count + COUNT_W'(1);
      if (w_bad_op) r_illegal <= 1'b1;
    end
  end

  // Reset presents the FETCH decode immediately, without the write strobes.
  assign w_dec_state = reset ? S_FETCH : r_state;
  assign w_dec_ready = mem_ready & ~reset;

  mips_mc_decode u_decode (
    .i_state      (w_dec_state),
    .i_mem_ready  (w_dec_ready),
    .i_zero       (zero),
    .o_pc_write   (pc_write),
    .o_ir_write   (ir_write),
    .o_iord       (iord),
    .o_mem_read   (mem_read),
    .o_mem_write  (mem_write),
    .o_reg_write  (reg_write),
    .o_alu_src_a  (alu_src_a),
    .o_reg_dst    (reg_dst),
    .o_mem_to_reg (mem_to_reg),
    .o_alu_src_b  (alu_src_b),
    .o_alu_op     (alu_op),
    .o_pc_src     (pc_src)
  );

  assign state       = r_state;
  assign instr_count = r_count;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed + randomized bench for mips_mc_ctrl against a per-instruction path model.
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    opcode, funct;
  logic          zero, mem_ready;
  logic          pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a;
  logic [1:0]    reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;
  logic          illegal;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .state(state),
    .instr_count(instr_count), .illegal(illegal)
  );

  typedef struct packed {
    logic pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src;
  } ctrl_t;

  typedef struct {
    state_t s;
    bit     rdy;
  } step_t;

  ctrl_t         obs;
  step_t         path[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] m_count = '0;
  bit            m_illegal = 1'b0;

  assign obs = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a,
                reg_dst, mem_to_reg, alu_src_b, alu_op, pc_src};

  // Control outputs each state must show, written straight from the state table.
  function automatic ctrl_t exp_ctrl(state_t s, bit rdy, bit z);
    ctrl_t c = '0;
    case (s)
      S_FETCH:  begin c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = rdy; c.pc_write = rdy; end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      S_MEMRD:  begin c.mem_read = 1; c.iord = 1; end
      S_MEMWB:  begin c.reg_write = 1; c.mem_to_reg = 2'b01; end
      S_MEMWR:  begin c.mem_write = 1; c.iord = 1; end
      S_EXEC:   begin c.alu_src_a = 1; c.alu_op = 2'b10; end
      S_ALUWB:  begin c.reg_write = 1; c.reg_dst = 2'b01; end
      S_ADDIEX: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      S_ADDIWB: c.reg_write = 1;
      S_BRANCH: begin c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_write = z; end
      S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1; end
      S_JR:     begin c.pc_src = 2'b11; c.pc_write = 1; end
      default:  ;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input state_t s, input bit rdy);
    step_t st;
    st.s = s;
    st.rdy = rdy;
    path.push_back(st);
  endtask

  // Expected cycle-by-cycle path of one instruction; fw/dw are memory wait cycles.
  task automatic build_path(input logic [5:0] op, input logic [5:0] fn, input int fw, input int dw);
    path.delete();
    repeat (fw) push(S_FETCH, 0);
    push(S_FETCH, 1);
    push(S_DECODE, 1);
    case (op)
      OP_LW: begin
        push(S_MEMADR, 1);
        repeat (dw) push(S_MEMRD, 0);
        push(S_MEMRD, 1);
        push(S_MEMWB, 1);
      end
      OP_SW: begin
        push(S_MEMADR, 1);
        repeat (dw) push(S_MEMWR, 0);
        push(S_MEMWR, 1);
      end
      OP_RTYPE: begin
        if (fn == FN_JR) push(S_JR, 1);
        else begin push(S_EXEC, 1); push(S_ALUWB, 1); end
      end
      OP_ADDI: begin push(S_ADDIEX, 1); push(S_ADDIWB, 1); end
      OP_BEQ:  push(S_BRANCH, 1);
      OP_J:    push(S_JUMP, 1);
      default: ;
    endcase
  endtask

  // Runs one instruction from FETCH; abort_at >= 0 stops before that cycle (no retire).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                           input int fw, input int dw, input int abort_at);
    build_path(op, fn, fw, dw);
    for (int i = 0; i < path.size(); i++) begin
      if (i == abort_at) return;
      opcode = op; funct = fn; zero = z; mem_ready = path[i].rdy;
      #1;
      chk("state", 32'(state), 32'(path[i].s));
      chk("ctrl", 32'(obs), 32'(exp_ctrl(path[i].s, path[i].rdy, z)));
      chk("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
      chk("count", 32'(instr_count), 32'(m_count));
      chk("illegal", 32'(illegal), 32'(m_illegal));
      @(posedge clk); #1;
    end
    if (path[path.size()-1].s == S_DECODE) m_illegal = 1'b1;
    else m_count = m_count + 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1;
    #1;
    chk("rst_ctrl", 32'(obs), 32'(exp_ctrl(S_FETCH, 0, 0)));
    @(posedge clk); #1;
    chk("rst_state", 32'(state), 32'(S_FETCH));
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    reset = 1'b0;
    m_count = '0;
    m_illegal = 1'b0;
  endtask

  logic [5:0] legal_ops [6];
  logic [5:0] rop, rfn;

  initial begin
    legal_ops[0] = OP_RTYPE; legal_ops[1] = OP_LW;  legal_ops[2] = OP_SW;
    legal_ops[3] = OP_ADDI;  legal_ops[4] = OP_BEQ; legal_ops[5] = OP_J;
    opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0; reset = 1'b1;

    do_reset();
    run_instr(OP_LW, 6'h00, 0, 0, 0, -1);
    chk("lw_retired", 32'(instr_count), 32'd1);
    run_instr(OP_BEQ, 6'h00, 1, 0, 0, -1);
    run_instr(OP_BEQ, 6'h00, 0, 0, 0, -1);
    chk("beq_pair", 32'(instr_count), 32'd3);
    run_instr(OP_SW, 6'h00, 0, 0, 3, -1);
    run_instr(6'b111111, 6'h00, 0, 0, 0, -1);
    run_instr(OP_ADDI, 6'h00, 0, 0, 0, -1);
    chk("illegal_sticky", 32'(illegal), 32'd1);

    do_reset();
    for (int k = 0; k < 16; k++) run_instr(OP_RTYPE, 6'b100000, k[0], 0, 0, -1);
    chk("count_wrap", 32'(instr_count), 32'd0);
    run_instr(OP_RTYPE, FN_JR, 0, 1, 0, -1);

    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 7) == 0) rop = 6'b110000 | 6'($urandom_range(0, 15));
      else rop = legal_ops[$urandom_range(0, 5)];
      rfn = ($urandom_range(0, 3) == 0) ? FN_JR : 6'($urandom);
      run_instr(rop, rfn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    // Reset lands during a MEMRD wait cycle.
    run_instr(OP_LW, 6'h00, 0, 0, 3, 4);
    chk("abort_in_memrd", 32'(state), 32'(S_MEMRD));
    do_reset();
    run_instr(OP_ADDI, 6'h00, 0, 0, 0, -1);
    chk("post_reset_count", 32'(instr_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
